// File: rtl/conv_result_writer_if.sv
// ---------------------------------------------------------------------------
// conv_result_writer_if
// Groups the two data paths of the result writer:
//   - result stream from the MAC : in_valid, in_data, in_ready
//   - shared-memory write port   : mem_wr_en, mem_wr_adr, mem_wr_data, mem_grant
// Modports:
//   slave  : the writer itself (consumes the stream, drives the write port)
//   master : the environment (produces the stream, grants memory writes)
// ---------------------------------------------------------------------------
interface conv_result_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_wr_en;
  logic [ADR_W-1:0]  mem_wr_adr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_grant;

  modport slave (
    input  in_valid, in_data, mem_grant,
    output in_ready, mem_wr_en, mem_wr_adr, mem_wr_data
  );

  modport master (
    output in_valid, in_data, mem_grant,
    input  in_ready, mem_wr_en, mem_wr_adr, mem_wr_data
  );
endinterface

// File: rtl/conv_result_writer.sv
// ---------------------------------------------------------------------------
// conv_result_writer
// Last stage of the convolution datapath. Accepts packed result words (four
// signed 8-bit lanes), optionally clamps negative lanes to zero (ReLU),
// buffers them in a DEPTH-entry FIFO and writes them to shared memory at
// base + index. Signals done after NUM_WORDS words have been committed.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   start_i       : run start pulse (honoured only in IDLE)
//   base_adr_i    : write base address, sampled with start_i
//   relu_en_i     : ReLU enable, sampled with start_i
//   bus           : result stream + memory write port (slave modport)
//   busy_o        : high while running or flushing
//   done_o        : one-cycle completion pulse
//   wr_count_o    : words committed to memory in the current run
// ---------------------------------------------------------------------------
module conv_result_writer #(
  parameter int DEPTH     = 4,
  parameter int NUM_WORDS = 43,
  parameter int DATA_W    = 32,
  parameter int ADR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [ADR_W-1:0]     base_adr_i,
  input  logic                 relu_en_i,
  conv_result_writer_if.slave  bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADR_W-1:0]     wr_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PW    = PTR_W + 1;
  localparam logic [ADR_W-1:0] NUM_W = ADR_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Clamp every negative lane to zero when enabled; lanes are independent.
  function automatic logic [DATA_W-1:0] relu_f(input logic [DATA_W-1:0] w,
                                               input logic en);
    logic [DATA_W-1:0] r;
    r = w;
    for (int k = 0; k < DATA_W / 8; k++) begin
      if (en && w[8*k+7]) begin
        r[8*k +: 8] = 8'h00;
      end
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [ADR_W-1:0]   base_q, base_d;
  logic               relu_q, relu_d;
  logic [ADR_W-1:0]   acc_q, acc_d;
  logic [ADR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic [DATA_W-1:0]  fifo_q [DEPTH];

  logic in_ready_s;
  logic mem_wr_en_s;
  logic push_s;
  logic pop_s;
  logic active_s;

  assign active_s   = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign in_ready_s = (state_q == S_RUN) && !full_q;
  // rst gates the request so no write can complete on a reset edge.
  assign mem_wr_en_s = rst && active_s && !empty_q;
  // full_q already blocks in_ready, so a pop in the same cycle never enables a push.
  assign push_s     = bus.in_valid && in_ready_s;
  assign pop_s      = mem_wr_en_s && bus.mem_grant;

  // FIFO pointer arithmetic; the extra MSB distinguishes full from empty.
  always_comb begin
    wptr_d  = wptr_q + PW'(push_s);
    rptr_d  = rptr_q + PW'(pop_s);
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[PTR_W] != rptr_d[PTR_W]) &&
              (wptr_d[PTR_W-1:0] == rptr_d[PTR_W-1:0]);
  end

  // Run sequencing: next state, run parameters and the two word counters.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    relu_d   = relu_q;
    acc_d    = acc_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_RUN;
          base_d   = base_adr_i;
          relu_d   = relu_en_i;
          acc_d    = {ADR_W{1'b0}};
          wr_cnt_d = {ADR_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_q + ADR_W'(push_s);
        wr_cnt_d = wr_cnt_q + ADR_W'(pop_s);
        if ((wr_cnt_d == NUM_W) && (acc_d == NUM_W)) begin
          state_d = S_DONE;
        end else if (acc_d == NUM_W) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        wr_cnt_d = wr_cnt_q + ADR_W'(pop_s);
        if (wr_cnt_d == NUM_W) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and FIFO status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      base_q   <= {ADR_W{1'b0}};
      relu_q   <= 1'b0;
      acc_q    <= {ADR_W{1'b0}};
      wr_cnt_q <= {ADR_W{1'b0}};
      wptr_q   <= {PW{1'b0}};
      rptr_q   <= {PW{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      relu_q   <= relu_d;
      acc_q    <= acc_d;
      wr_cnt_q <= wr_cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // FIFO storage; words are stored already ReLU-processed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wptr_q[PTR_W-1:0]] <= relu_f(bus.in_data, relu_q);
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.mem_wr_en   = mem_wr_en_s;
  assign bus.mem_wr_data = fifo_q[rptr_q[PTR_W-1:0]];
  assign bus.mem_wr_adr  = base_q + wr_cnt_q;
  assign busy_o          = active_s;
  assign done_o          = (state_q == S_DONE);
  assign wr_count_o      = wr_cnt_q;

endmodule
